vx_warp_issue_sched: RTL and testbench



---
 rtl/VX_gpu_pkg.sv | 14 +
 rtl/vx_warp_ibuf.sv | 39 +++
 rtl/vx_warp_issue_sched.sv | 108 ++++++++++
 tb/tb_vx_warp_issue_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg: shared issue-stage types and default widths
package VX_gpu_pkg;
    localparam int WB         = 2;
    localparam int NRB        = 6;
    localparam int IBUF_DATAW = 64;
    typedef struct packed {
        logic [IBUF_DATAW-1:0] data;
        logic                  wb;
        logic [NRB-1:0]        rd;
        logic [NRB-1:0]        rs1;
        logic [NRB-1:0]        rs2;
        logic [NRB-1:0]        rs3;
    } ibuf_entry_t;
endpackage

// File: rtl/vx_warp_ibuf.sv
// vx_warp_ibuf: single-warp instruction FIFO with registered head entry
module vx_warp_ibuf
    import VX_gpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  ibuf_entry_t i_data,
    output ibuf_entry_t o_head,
    output logic        o_empty,
    output logic        o_full
);
    ibuf_entry_t     r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (i_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/vx_warp_issue_sched.sv
// vx_warp_issue_sched: per-warp instruction buffers, scoreboard and
// round-robin selection of one hazard-free warp into a registered issue slot
module vx_warp_issue_sched
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS     = 2 ** WB,
    parameter int IBUF_DEPTH    = 2,
    parameter int NUM_REGS      = 2 ** NRB,
    parameter int DATAW         = IBUF_DATAW,
    parameter int PERF_CTR_BITS = 44,
    localparam int WIDW = $clog2(NUM_WARPS),
    localparam int RIDW = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic [WIDW-1:0]          dec_wid,
    input  logic [DATAW-1:0]         dec_data,
    input  logic                     dec_wb,
    input  logic [RIDW-1:0]          dec_rd,
    input  logic [RIDW-1:0]          dec_rs1,
    input  logic [RIDW-1:0]          dec_rs2,
    input  logic [RIDW-1:0]          dec_rs3,
    output logic                     dec_ready,
    output logic                     iss_valid,
    output logic [WIDW-1:0]          iss_wid,
    output logic [DATAW-1:0]         iss_data,
    output logic                     iss_wb,
    output logic [RIDW-1:0]          iss_rd,
    input  logic                     iss_ready,
    input  logic                     wb_valid,
    input  logic [WIDW-1:0]          wb_wid,
    input  logic [RIDW-1:0]          wb_rd,
    input  logic                     wb_eop,
    output logic [PERF_CTR_BITS-1:0] perf_scb_stalls,
    output logic [PERF_CTR_BITS-1:0] perf_ibf_stalls
);
    logic [NUM_REGS-1:0]  r_inuse [NUM_WARPS];
    logic [WIDW-1:0]      r_rr_ptr;
    ibuf_entry_t          w_head [NUM_WARPS];
    ibuf_entry_t          w_dec_entry;
    ibuf_entry_t          w_sel;
    logic [NUM_WARPS-1:0] w_empty, w_full, w_elig, w_push, w_pop;
    logic [WIDW-1:0]      w_gnt_wid, w_idx;
    logic                 w_any, w_slot_free, w_grant;
    assign w_dec_entry = '{data: dec_data, wb: dec_wb, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, rs3: dec_rs3};
    assign dec_ready   = !w_full[dec_wid];
    assign w_slot_free = !iss_valid || iss_ready;
    assign w_grant     = w_slot_free && w_any;
    assign w_sel       = w_head[w_gnt_wid];
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        assign w_push[g] = dec_valid && dec_ready && (dec_wid == WIDW'(g));
        assign w_pop[g]  = w_grant && (w_gnt_wid == WIDW'(g));
        // rd is checked only for writers; r0 is never marked so it never blocks
        assign w_elig[g] = !w_empty[g] && !r_inuse[g][w_head[g].rs1] && !r_inuse[g][w_head[g].rs2]
                         && !r_inuse[g][w_head[g].rs3] && !(w_head[g].wb && r_inuse[g][w_head[g].rd]);
        vx_warp_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (w_dec_entry),
            .o_head  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
    end
    // first eligible warp strictly after r_rr_ptr, wrapping back to r_rr_ptr last
    always_comb begin
        w_gnt_wid = r_rr_ptr;
        w_any     = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_idx = r_rr_ptr + WIDW'(i);
            if (!w_any && w_elig[w_idx]) begin
                w_any     = 1'b1;
                w_gnt_wid = w_idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid       <= 1'b0;
            iss_wid         <= '0;
            iss_data        <= '0;
            iss_wb          <= 1'b0;
            iss_rd          <= '0;
            r_rr_ptr        <= '1;
            perf_scb_stalls <= '0;
            perf_ibf_stalls <= '0;
            for (int w = 0; w < NUM_WARPS; w++) r_inuse[w] <= '0;
        end else begin
            if (w_slot_free) iss_valid <= w_any;
            if (w_grant) begin
                iss_wid  <= w_gnt_wid;
                iss_data <= w_sel.data;
                iss_wb   <= w_sel.wb;
                iss_rd   <= w_sel.rd;
                r_rr_ptr <= w_gnt_wid;
            end
            if (w_slot_free && !(&w_empty) && !w_any) perf_scb_stalls <= perf_scb_stalls + 1'b1;
            if (dec_valid && !dec_ready) perf_ibf_stalls <= perf_ibf_stalls + 1'b1;
            // the set is written after the clear so it wins on a same-cycle collision
            if (wb_valid && wb_eop) r_inuse[wb_wid][wb_rd] <= 1'b0;
            if (w_grant && w_sel.wb && (w_sel.rd != '0)) r_inuse[w_gnt_wid][w_sel.rd] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vx_warp_issue_sched.sv
// tb_vx_warp_issue_sched: directed checks of enqueue, scoreboard hazards,
// round-robin order, back-pressure, set/clear collision and mid-run reset
module tb_vx_warp_issue_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_valid = 1'b0;
    logic [1:0]  dec_wid = '0;
    logic [63:0] dec_data = '0;
    logic        dec_wb = 1'b0;
    logic [5:0]  dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rs3 = '0;
    logic        dec_ready;
    logic        iss_valid;
    logic [1:0]  iss_wid;
    logic [63:0] iss_data;
    logic        iss_wb;
    logic [5:0]  iss_rd;
    logic        iss_ready = 1'b1;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_wid = '0;
    logic [5:0]  wb_rd = '0;
    logic        wb_eop = 1'b0;
    logic [43:0] perf_scb_stalls, perf_ibf_stalls;
    int checks = 0;
    int errors = 0;
    vx_warp_issue_sched dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_wid(dec_wid), .dec_data(dec_data), .dec_wb(dec_wb),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .dec_ready(dec_ready),
        .iss_valid(iss_valid), .iss_wid(iss_wid), .iss_data(iss_data), .iss_wb(iss_wb), .iss_rd(iss_rd),
        .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .perf_scb_stalls(perf_scb_stalls), .perf_ibf_stalls(perf_ibf_stalls)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [1:0] wid, input logic [63:0] d, input logic wb,
                        input logic [5:0] rd, input logic [5:0] rs1);
        dec_valid = 1'b1; dec_wid = wid; dec_data = d; dec_wb = wb; dec_rd = rd; dec_rs1 = rs1;
        tick();
        dec_valid = 1'b0;
    endtask
    task automatic wb(input logic [1:0] wid, input logic [5:0] rd, input logic eop);
        wb_valid = 1'b1; wb_wid = wid; wb_rd = rd; wb_eop = eop;
        tick();
        wb_valid = 1'b0;
    endtask
    logic [63:0] rr_data [9];
    logic [1:0]  rr_wid  [9];
    initial begin
        rr_data = '{64'h30, 64'h40, 64'h50, 64'h60, 64'h31, 64'h41, 64'h51, 64'h61, 64'h32};
        rr_wid  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        tick(); tick();
        reset = 1'b0;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_data", iss_data, 0);
        chk("rst_iss_rd", iss_rd, 0);
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_scb_ctr", perf_scb_stalls, 0);
        chk("rst_ibf_ctr", perf_ibf_stalls, 0);
        // single instruction: visible two cycles after the push cycle
        push(2'd0, 64'hA0, 1'b1, 6'd5, 6'd0);
        chk("single_n1_idle", iss_valid, 0);
        tick();
        chk("single_valid", iss_valid, 1);
        chk("single_wid", iss_wid, 0);
        chk("single_rd", iss_rd, 5);
        chk("single_data", iss_data, 64'hA0);
        chk("single_wb", iss_wb, 1);
        chk("single_inuse", dut.r_inuse[0][5], 1);
        tick();
        chk("single_drain", iss_valid, 0);
        wb(2'd0, 6'd5, 1'b1);
        chk("single_cleared", dut.r_inuse[0][5], 0);
        // RAW hazard on warp 1
        push(2'd1, 64'hB0, 1'b1, 6'd3, 6'd0);
        push(2'd1, 64'hB1, 1'b0, 6'd0, 6'd3);
        chk("raw_first_data", iss_data, 64'hB0);
        wb(2'd1, 6'd3, 1'b0);
        tick();
        chk("raw_noeop_held", iss_valid, 0);
        chk("raw_scb_ctr", perf_scb_stalls, 2);
        wb(2'd1, 6'd3, 1'b1);
        chk("raw_n1_idle", iss_valid, 0);
        tick();
        chk("raw_n2_valid", iss_valid, 1);
        chk("raw_n2_data", iss_data, 64'hB1);
        chk("raw_scb_final", perf_scb_stalls, 3);
        tick();
        // round robin with the slot held for the whole fill
        iss_ready = 1'b0;
        push(2'd0, 64'h30, 1'b0, 6'd0, 6'd0);
        push(2'd0, 64'h31, 1'b0, 6'd0, 6'd0);
        chk("hold_valid", iss_valid, 1);
        push(2'd0, 64'h32, 1'b0, 6'd0, 6'd0);
        for (int w = 1; w < 4; w++) begin
            push(2'(w), 64'h30 + 64'(16 * w), 1'b0, 6'd0, 6'd0);
            push(2'(w), 64'h31 + 64'(16 * w), 1'b0, 6'd0, 6'd0);
            chk("hold_data", iss_data, 64'h30);
            chk("hold_wid", iss_wid, 0);
        end
        iss_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("rr_wid", iss_wid, rr_wid[i]);
            chk("rr_data", iss_data, rr_data[i]);
            tick();
        end
        chk("rr_drain", iss_valid, 0);
        // full FIFO on warp 2
        iss_ready = 1'b0;
        push(2'd2, 64'h70, 1'b0, 6'd0, 6'd0);
        push(2'd2, 64'h71, 1'b0, 6'd0, 6'd0);
        push(2'd2, 64'h72, 1'b0, 6'd0, 6'd0);
        dec_valid = 1'b1; dec_wid = 2'd2; dec_data = 64'h73;
        #1 chk("full_w2_ready", dec_ready, 0);
        dec_wid = 2'd3;
        #1 chk("full_w3_ready", dec_ready, 1);
        dec_wid = 2'd2;
        tick(); tick();
        dec_valid = 1'b0;
        chk("full_ibf_ctr", perf_ibf_stalls, 2);
        chk("full_hold_data", iss_data, 64'h70);
        iss_ready = 1'b1;
        tick();
        chk("full_drain1", iss_data, 64'h71);
        tick();
        chk("full_drain2", iss_data, 64'h72);
        tick();
        chk("full_drain_idle", iss_valid, 0);
        // same-cycle set and clear of inuse[0][7]
        push(2'd0, 64'h80, 1'b1, 6'd7, 6'd0);
        wb(2'd0, 6'd7, 1'b1);
        chk("setclr_data", iss_data, 64'h80);
        chk("setclr_inuse", dut.r_inuse[0][7], 1);
        wb(2'd0, 6'd7, 1'b1);
        chk("setclr_cleared", dut.r_inuse[0][7], 0);
        // rd=0 writers never block each other
        push(2'd0, 64'h90, 1'b1, 6'd0, 6'd0);
        push(2'd0, 64'h91, 1'b1, 6'd0, 6'd0);
        chk("r0_first", iss_data, 64'h90);
        tick();
        chk("r0_second_valid", iss_valid, 1);
        chk("r0_second_data", iss_data, 64'h91);
        chk("r0_inuse", dut.r_inuse[0][0], 0);
        tick();
        // mid-operation reset with buffered and in-slot work
        iss_ready = 1'b0;
        push(2'd1, 64'hA0, 1'b1, 6'd9, 6'd0);
        push(2'd1, 64'hA1, 1'b0, 6'd0, 6'd0);
        push(2'd2, 64'hA2, 1'b0, 6'd0, 6'd0);
        push(2'd3, 64'hA3, 1'b0, 6'd0, 6'd0);
        reset = 1'b1;
        wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 6'd9; wb_eop = 1'b1;
        tick();
        wb_valid = 1'b0;
        reset = 1'b0;
        dec_wid = 2'd1;
        #1;
        chk("mrst_iss_valid", iss_valid, 0);
        chk("mrst_iss_data", iss_data, 0);
        chk("mrst_scb_ctr", perf_scb_stalls, 0);
        chk("mrst_ibf_ctr", perf_ibf_stalls, 0);
        chk("mrst_dec_ready", dec_ready, 1);
        chk("mrst_inuse", dut.r_inuse[1][9], 0);
        iss_ready = 1'b1;
        tick(); tick();
        chk("mrst_empty", iss_valid, 0);
        push(2'd0, 64'hC0, 1'b0, 6'd0, 6'd0);
        tick();
        chk("mrst_w0_valid", iss_valid, 1);
        chk("mrst_w0_wid", iss_wid, 0);
        chk("mrst_w0_data", iss_data, 64'hC0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
